// File: rtl/sig_pkg.sv
// Shared definitions for the SIG_* statistic stream wrappers.
// Combinational constants only; no latency, no flow control.
// Backpressure: not applicable.
package sig_pkg;

    localparam int RES_BITS_PER_PIX = 16;

    typedef enum logic [0:0] {
        ST_STREAM = 1'b0,
        ST_FLUSH  = 1'b1
    } feed_state_e;

    function automatic int beats_per_frame(input int image_dim, input int pixels_per_beat);
        return (image_dim * image_dim) / pixels_per_beat;
    endfunction

endpackage

// File: rtl/sig_token_track.sv
// Token shift register marking which stall-gated pipeline slots hold real data, plus output framing.
// Latency: a token reaches the tail LATENCY advances after entering the head.
// Backpressure: a tail result handed off without an advance is masked until the next advance.
module sig_token_track #(
    parameter int LATENCY = 4,
    parameter int BEATS   = 16
) (
    input  logic clk,
    input  logic aresetn,
    input  logic adv,
    input  logic head_bit,
    input  logic m_tready,
    output logic m_tvalid,
    output logic m_tlast
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [LATENCY-1:0] tok_q, tok_d;
    logic               tail_taken_q, tail_taken_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_hs;

    assign m_tvalid = tok_q[LATENCY-1] & ~tail_taken_q;
    assign m_tlast  = m_tvalid & (out_cnt_q == LAST_BEAT);
    assign out_hs   = m_tvalid & m_tready;

    always_comb begin
        tok_d        = tok_q;
        tail_taken_d = tail_taken_q;
        out_cnt_d    = out_cnt_q;
        if (adv) begin
            tok_d        = tok_q << 1;
            tok_d[0]     = head_bit;
            tail_taken_d = 1'b0;
        end else if (out_hs) begin
            // Pipeline is frozen, so the same tail result stays on res_in; deliver it once.
            tail_taken_d = 1'b1;
        end
        if (out_hs) begin
            out_cnt_d = (out_cnt_q == LAST_BEAT) ? '0 : out_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tok_q        <= '0;
            tail_taken_q <= 1'b0;
            out_cnt_q    <= '0;
        end else begin
            tok_q        <= tok_d;
            tail_taken_q <= tail_taken_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

endmodule

// File: rtl/sig_stream_feeder.sv
// Pairs x/y pixel streams into the stall-gated SIG_* pipeline, returns results as a stream, flushes per frame.
// Latency: LATENCY advancing cycles input pair to result; LATENCY zero flush beats follow each frame.
// Backpressure: m_tready low with a valid result, or a missing x/y beat, freezes the pipeline via stall.
module sig_stream_feeder
    import sig_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int RES_WIDTH       = 2 * DATA_WIDTH,
    parameter int LATENCY         = 4
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_x_tdata,
    input  logic                  s_x_tvalid,
    input  logic                  s_x_tlast,
    output logic                  s_x_tready,
    input  logic [DATA_WIDTH-1:0] s_y_tdata,
    input  logic                  s_y_tvalid,
    input  logic                  s_y_tlast,
    output logic                  s_y_tready,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    input  logic [RES_WIDTH-1:0]  res_in,
    output logic [RES_WIDTH-1:0]  m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  err_tlast
);

    localparam int BEATS = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FL_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [FL_W-1:0]  LAST_FLUSH = FL_W'(LATENCY - 1);

    feed_state_e      state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic             err_tlast_q, err_tlast_d;

    logic streaming;
    logic blocked;
    logic adv;
    logic last_beat;

    assign streaming = (state_q == ST_STREAM);
    assign blocked   = m_tvalid & ~m_tready;
    assign last_beat = (in_cnt_q == LAST_BEAT);

    // aresetn gates adv directly so stall/tready are safe while reset is held.
    always_comb begin
        adv = 1'b0;
        if (aresetn) begin
            adv = streaming ? (~blocked & s_x_tvalid & s_y_tvalid) : ~blocked;
        end
    end

    assign s_x_tready = adv & streaming;
    assign s_y_tready = adv & streaming;
    assign stall      = ~adv;
    assign out_x      = streaming ? s_x_tdata : '0;
    assign out_y      = streaming ? s_y_tdata : '0;
    assign m_tdata    = res_in;
    assign err_tlast  = err_tlast_q;

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        flush_cnt_d = flush_cnt_q;
        err_tlast_d = err_tlast_q;
        if (adv) begin
            if (streaming) begin
                if ((s_x_tlast != last_beat) || (s_y_tlast != last_beat)) begin
                    err_tlast_d = 1'b1;
                end
                if (last_beat) begin
                    in_cnt_d    = '0;
                    flush_cnt_d = '0;
                    state_d     = ST_FLUSH;
                end else begin
                    in_cnt_d = in_cnt_q + 1'b1;
                end
            end else begin
                if (flush_cnt_q == LAST_FLUSH) begin
                    flush_cnt_d = '0;
                    state_d     = ST_STREAM;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_STREAM;
            in_cnt_q    <= '0;
            flush_cnt_q <= '0;
            err_tlast_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_tlast_q <= err_tlast_d;
        end
    end

    sig_token_track #(
        .LATENCY (LATENCY),
        .BEATS   (BEATS)
    ) u_token_track (
        .clk      (clk),
        .aresetn  (aresetn),
        .adv      (adv),
        .head_bit (streaming),
        .m_tready (m_tready),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast)
    );

endmodule

// File: doc/sig_stream_feeder.md
Name: sig_stream_feeder

Overview:
- Drives the stall-gated SIG_* statistic pipelines (x/y multiply → Gaussian → difference) from two AXI-Stream pixel sources, then returns the pipeline result as an AXI-Stream master.
- Pairs the x and y beats and generates the global stall.
- Tracks which pipeline slots hold real data with a token shift register.
- After each frame, injects zero flush beats so the Gaussian line buffers drain.

Parameters:
- PIXELS_PER_BEAT, 16, 8-bit pixels per beat.
- IMAGE_DIM, 512, frame width and height in pixels.
- DATA_WIDTH, 8*PIXELS_PER_BEAT, input beat width.
- RES_WIDTH, 2*DATA_WIDTH, result beat width.
- LATENCY, 4, advancing cycles from a beat on out_x/out_y to its result on res_in. Includes the Gaussian vertical delay; must be ≥1.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_x_tdata  in  DATA_WIDTH  x pixels
- s_x_tvalid  in  1
- s_x_tlast  in  1  end of frame, x
- s_x_tready  out  1
- s_y_tdata  in  DATA_WIDTH  y pixels
- s_y_tvalid  in  1
- s_y_tlast  in  1  end of frame, y
- s_y_tready  out  1
- stall  out  1  freeze for the downstream statistic pipeline
- out_x  out  DATA_WIDTH  pipeline in_x
- out_y  out  DATA_WIDTH  pipeline in_y
- res_in  in  RES_WIDTH  pipeline out
- m_tdata  out  RES_WIDTH
- m_tvalid  out  1
- m_tlast  out  1
- m_tready  in  1
- err_tlast  out  1  sticky frame-length mismatch

Behaviour:
- BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT.
- Clock is clk; reset is aresetn, asynchronous and active-low.
- Reset clears: state=STREAM, token register tok[LATENCY-1:0], in_cnt, out_cnt, flush_cnt, err_tlast, tail_taken.
- Outputs while reset is asserted: stall=1, s_*_tready=0, m_tvalid=0.
- blocked = m_tvalid & ~m_tready.
- STREAM state:
  - adv = ~blocked & s_x_tvalid & s_y_tvalid.
  - s_x_tready = s_y_tready = adv, so both beats are always accepted together.
  - out_x/out_y = s_x_tdata/s_y_tdata, combinational. The pipeline's first stage registers them.
- FLUSH state:
  - adv = ~blocked.
  - s_*_tready = 0; out_x = out_y = 0.
- stall = ~adv, combinational from m_tready and the two tvalids. Consumers must not feed stall back into tvalid/tready.
- Token register, on adv:
  - tok shifts toward the tail.
  - New head bit = 1 in STREAM, 0 in FLUSH.
  - tail_taken clears.
- m_tvalid = tok[tail] & ~tail_taken; m_tdata = res_in.
- Output handshake without adv sets tail_taken. A frozen result is therefore delivered exactly once.
- Handshake coincident with adv: the shift replaces the tail normally.
- Counters:
  - in_cnt increments per accepted pair.
  - At in_cnt == BEATS-1 with adv: in_cnt←0, flush_cnt←0, state←FLUSH.
  - FLUSH: flush_cnt increments per adv. After LATENCY flush advances, state←STREAM.
- Simultaneous last input beat and output stall: the transition waits for adv.
- err_tlast is set when an accepted pair has s_x_tlast or s_y_tlast ≠ (in_cnt == BEATS-1). It is cleared only by reset. Data is not altered on error.
- out_cnt increments per output handshake and wraps at BEATS-1. m_tlast = m_tvalid & (out_cnt == BEATS-1).
- Next frame's inputs are not accepted during FLUSH. Throughput: BEATS per BEATS+LATENCY cycles.
- Reset mid-frame: all tokens are dropped. Downstream pipeline contents are don't-care because every token is 0.

Decomposition:
- Shared package sig_pkg:
  - BEATS_PER_FRAME function of IMAGE_DIM/PIXELS_PER_BEAT.
  - Result width constant 16 bits per pixel.
  - STREAM/FLUSH state encoding.
- One natural sub-module, sig_token_track: the token shift register with tail_taken and out_cnt/m_tlast. It is reusable for the SIG_X/SIG_Y/SIG_XY wrappers.

Test Plan:
All scenarios use IMAGE_DIM=8, PIXELS_PER_BEAT=4 (BEATS=16), LATENCY=4, with the pipeline modelled as a 4-stage stall-gated delay.
- Continuous valid on both inputs, m_tready=1 → stall=0 for 16 cycles, then 4 zero flush beats. m_tvalid is high for exactly 16 cycles, starting 4 cycles after the first accept. m_tlast is on the 16th result; results equal the inputs in order.
- y lags x by 3 cycles → s_x_tready=0 until y is valid. Pairs stay aligned; result k equals the pair k model.
- m_tready low for 5 cycles while a result is valid → stall=1 throughout, m_tdata stable, no beat lost or duplicated.
- Input bubble with tail valid and m_tready=1 → result delivered once, m_tvalid drops until the next adv.
- s_x_tlast asserted on beat 10 → err_tlast=1 from the next cycle and stays set. The frame still emits 16 results.
- aresetn pulsed low mid-frame (beat 7) → m_tvalid=0 and stall=1 immediately. The next frame yields 16 results with m_tlast on the 16th.
